// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised register file for the RISC-V core.
// One block-RAM bank per read port plus one bank for the debug port. All
// banks receive the same writes. After reset a sweep writes zero to every
// entry before the file reports ready. Reads have one cycle of latency,
// with write-first forwarding and an optional hard-wired zero register.
// The debug port uses a req/ack handshake and reads its own dedicated bank.
module regfile_multiport #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int NUM_READ_PORTS = 2,
    parameter int ZERO_REG       = 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               write,
    input  logic [ADDR_WIDTH-1:0]              wrAddr,
    input  logic [DATA_WIDTH-1:0]              wrData,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rdAddr,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rdData,
    output logic                               ready,
    input  logic                               dbgReq,
    input  logic [ADDR_WIDTH-1:0]              dbgAddr,
    output logic                               dbgAck,
    output logic [DATA_WIDTH-1:0]              dbgData
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NUM_BANKS = NUM_READ_PORTS + 1;
    localparam int DBG_BANK  = NUM_READ_PORTS;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic {CLEAR, READY} topState_t;
    typedef enum logic {DBG_IDLE, DBG_BUSY} dbgState_t;
    // Where a registered read result comes from. The bank output register
    // stays free of reset so it maps onto the RAM's own output register.
    // Zeroing and forwarding are therefore applied after the RAM.
    typedef enum logic [1:0] {SRC_ZERO, SRC_FWD, SRC_BANK} rdSrc_t;

    // Top FSM and clear sweep
    topState_t             topState, topStateNext;
    logic [ADDR_WIDTH-1:0] sweepCount, sweepCountNext;

    // Debug handshake
    dbgState_t             dbgState, dbgStateNext;
    logic [ADDR_WIDTH-1:0] dbgAddrQ, dbgAddrNext;
    logic                  dbgAckNext;

    // Shared write port into every bank
    logic                  sweeping;
    logic                  commit;
    logic                  bankWe;
    logic [ADDR_WIDTH-1:0] bankWrAddr;
    logic [DATA_WIDTH-1:0] bankWrData;

    // Per-bank read side
    logic [ADDR_WIDTH-1:0] bankRdAddr [NUM_BANKS];
    logic [NUM_BANKS-1:0]  bankRdEn;
    logic [DATA_WIDTH-1:0] bankQ      [NUM_BANKS];
    rdSrc_t                srcNext    [NUM_BANKS];
    rdSrc_t                srcQ       [NUM_BANKS];
    logic [DATA_WIDTH-1:0] fwdQ;
    logic [DATA_WIDTH-1:0] dbgFwdQ;

    assign sweeping = (topState == CLEAR);
    assign ready    = (topState == READY);

    // Writes are taken only once the sweep is done. Address 0 is skipped when
    // it is hard-wired to zero.
    assign commit = write && (topState == READY) &&
                    !((ZERO_REG != 0) && (wrAddr == '0));

    // During the sweep the counter owns the write port. After that, the
    // external write port owns it.
    assign bankWe     = sweeping || commit;
    assign bankWrAddr = sweeping ? sweepCount : wrAddr;
    assign bankWrData = sweeping ? '0 : wrData;

    // Top FSM state register and sweep counter.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values; blocking assignments here would make simulation depend on process order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            topState   <= CLEAR;
            sweepCount <= '0;
        end else begin
            topState   <= topStateNext;
            sweepCount <= sweepCountNext;
        end
    end

    // Top FSM next state: zero one address per cycle, then stay in READY until reset.
    // NOTE: each output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        topStateNext   = topState;
        sweepCountNext = sweepCount;
        if (topState == CLEAR) begin
            sweepCountNext = sweepCount + ADDR_ONE;
            if (sweepCount == LAST_ADDR) begin
                topStateNext = READY;
            end
        end
    end

    // Read address and enable per bank. Read-port banks read every cycle.
    // The debug bank reads only while a request is in flight, so its result
    // holds until the next ack.
    always_comb begin
        bankRdEn = '0;
        for (int k = 0; k < NUM_READ_PORTS; k++) begin
            bankRdAddr[k] = rdAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
            bankRdEn[k]   = 1'b1;
        end
        bankRdAddr[DBG_BANK] = dbgAddrQ;
        bankRdEn[DBG_BANK]   = (dbgState == DBG_BUSY);
    end

    // Storage banks: identical contents, one independent read port each.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : gBank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] memQ;

        // Shared write and registered (read-first) read of this bank.
        // NOTE: the array has no reset; a reset term would prevent block-RAM inference, and the post-reset sweep provides the zero contents instead.
        always_ff @(posedge clk) begin
            if (bankWe) begin
                mem[bankWrAddr] <= bankWrData;
            end
            if (bankRdEn[b]) begin
                memQ <= mem[bankRdAddr[b]];
            end
        end

        assign bankQ[b] = memQ;
    end

    // Choose where each read result comes from. The zero register beats
    // forwarding, and forwarding beats the RAM, which would return the old
    // value during a same-cycle write.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            srcNext[b] = SRC_BANK;
            if (sweeping) begin
                srcNext[b] = SRC_ZERO;
            end else if ((ZERO_REG != 0) && (bankRdAddr[b] == '0)) begin
                srcNext[b] = SRC_ZERO;
            end else if (commit && (wrAddr == bankRdAddr[b])) begin
                srcNext[b] = SRC_FWD;
            end
        end
    end

    // Register the source selects and the forwarded data alongside the RAM read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                srcQ[b] <= SRC_ZERO;
            end
            fwdQ    <= '0;
            dbgFwdQ <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bankRdEn[b]) begin
                    srcQ[b] <= srcNext[b];
                end
            end
            fwdQ <= wrData;
            if (dbgState == DBG_BUSY) begin
                dbgFwdQ <= wrData;
            end
        end
    end

    // Read-port output mux: zero, forwarded write data, or RAM output.
    always_comb begin
        rdData = '0;
        for (int k = 0; k < NUM_READ_PORTS; k++) begin
            case (srcQ[k])
                SRC_FWD:  rdData[k*DATA_WIDTH +: DATA_WIDTH] = fwdQ;
                SRC_BANK: rdData[k*DATA_WIDTH +: DATA_WIDTH] = bankQ[k];
                default:  rdData[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            endcase
        end
    end

    // Debug output mux; holds because its inputs only update while BUSY.
    always_comb begin
        case (srcQ[DBG_BANK])
            SRC_FWD:  dbgData = dbgFwdQ;
            SRC_BANK: dbgData = bankQ[DBG_BANK];
            default:  dbgData = '0;
        endcase
    end

    // Debug FSM state register, captured address and ack pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbgState <= DBG_IDLE;
            dbgAddrQ <= '0;
            dbgAck   <= 1'b0;
        end else begin
            dbgState <= dbgStateNext;
            dbgAddrQ <= dbgAddrNext;
            dbgAck   <= dbgAckNext;
        end
    end

    // Debug FSM next state: accept in READY, then answer on the following
    // edge. A request that is still high during the ack cycle is not
    // accepted in that same cycle.
    always_comb begin
        dbgStateNext = dbgState;
        dbgAddrNext  = dbgAddrQ;
        dbgAckNext   = 1'b0;
        case (dbgState)
            DBG_IDLE: begin
                if (dbgReq && (topState == READY) && !dbgAck) begin
                    dbgStateNext = DBG_BUSY;
                    dbgAddrNext  = dbgAddr;
                end
            end
            DBG_BUSY: begin
                dbgStateNext = DBG_IDLE;
                dbgAckNext   = 1'b1;
            end
            default: dbgStateNext = DBG_IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Testbench for regfile_multiport: default 2-port 32x32 instance plus a
// 3-port 16-bit x 16-entry instance. Expected read/debug results are queued
// at issue time and consumed by monitors when the DUT presents them.
module tb_regfile_multiport;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NP  = 2;
    localparam int DWB = 16;
    localparam int AWB = 4;
    localparam int NPB = 3;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Instance A (defaults)
    logic             write;
    logic [AW-1:0]    wrAddr;
    logic [DW-1:0]    wrData;
    logic [NP*AW-1:0] rdAddr;
    logic [NP*DW-1:0] rdData;
    logic             ready;
    logic             dbgReq;
    logic [AW-1:0]    dbgAddr;
    logic             dbgAck;
    logic [DW-1:0]    dbgData;

    // Instance B (3 ports, 16 bits, 16 entries)
    logic               writeB;
    logic [AWB-1:0]     wrAddrB;
    logic [DWB-1:0]     wrDataB;
    logic [NPB*AWB-1:0] rdAddrB;
    logic [NPB*DWB-1:0] rdDataB;
    logic               readyB;
    logic               dbgReqB;
    logic [AWB-1:0]     dbgAddrB;
    logic               dbgAckB;
    logic [DWB-1:0]     dbgDataB;

    regfile_multiport dutA (
        .clk(clk), .reset_n(reset_n),
        .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddr(rdAddr), .rdData(rdData), .ready(ready),
        .dbgReq(dbgReq), .dbgAddr(dbgAddr), .dbgAck(dbgAck), .dbgData(dbgData)
    );

    regfile_multiport #(
        .DATA_WIDTH(DWB), .ADDR_WIDTH(AWB), .NUM_READ_PORTS(NPB), .ZERO_REG(1)
    ) dutB (
        .clk(clk), .reset_n(reset_n),
        .write(writeB), .wrAddr(wrAddrB), .wrData(wrDataB),
        .rdAddr(rdAddrB), .rdData(rdDataB), .ready(readyB),
        .dbgReq(dbgReqB), .dbgAddr(dbgAddrB), .dbgAck(dbgAckB), .dbgData(dbgDataB)
    );

    int nTests = 0;
    int nFail  = 0;

    logic [NP*DW-1:0]   rdExpQ  [$];
    logic [DW-1:0]      dbgExpQ [$];
    logic [NPB*DWB-1:0] rdExpQB [$];

    logic rdIssue  = 1'b0;
    logic rdPend   = 1'b0;
    logic rdIssueB = 1'b0;
    logic rdPendB  = 1'b0;
    int   cycle    = 0;
    int   lastAck  = -100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: advance to the next falling edge and drop one-shot strobes.
    task automatic step();
        @(negedge clk);
        write    = 1'b0;
        writeB   = 1'b0;
        rdIssue  = 1'b0;
        rdIssueB = 1'b0;
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write  = 1'b1;
        wrAddr = a;
        wrData = d;
    endtask

    task automatic doWriteB(input logic [AWB-1:0] a, input logic [DWB-1:0] d);
        writeB  = 1'b1;
        wrAddrB = a;
        wrDataB = d;
    endtask

    task automatic issueRead(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        rdAddr  = {a1, a0};
        rdIssue = 1'b1;
        rdExpQ.push_back({e1, e0});
    endtask

    task automatic issueReadB(input logic [AWB-1:0] a0, input logic [AWB-1:0] a1,
                              input logic [AWB-1:0] a2, input logic [NPB*DWB-1:0] e);
        rdAddrB  = {a2, a1, a0};
        rdIssueB = 1'b1;
        rdExpQB.push_back(e);
    endtask

    // Bounded wait for dbgAck, sampled on falling edges.
    task automatic waitAck(input string name, input int limit);
        int i;
        i = 0;
        while (!dbgAck && i < limit) begin
            @(negedge clk);
            i++;
        end
        if (!dbgAck) begin
            nTests++;
            nFail++;
            $display("FAIL %s: no dbgAck within %0d cycles", name, limit);
        end
    endtask

    // Read-valid pipeline and cycle count on the active edge.
    always @(posedge clk) begin
        rdPend  <= rdIssue;
        rdPendB <= rdIssueB;
        cycle   <= cycle + 1;
    end

    // Monitor: compare presented results against queued expectations.
    always @(negedge clk) begin
        if (rdPend) begin
            check("rd expectation present", rdExpQ.size() != 0, 1);
            if (rdExpQ.size() != 0) check("rd data", rdData, rdExpQ.pop_front());
        end
        if (rdPendB) begin
            check("rdB expectation present", rdExpQB.size() != 0, 1);
            if (rdExpQB.size() != 0) check("rdB data", rdDataB, rdExpQB.pop_front());
        end
        if (dbgAck) begin
            check("dbg ack spacing >= 2", (cycle - lastAck) >= 2, 1);
            lastAck = cycle;
            check("dbg ack expected", dbgExpQ.size() != 0, 1);
            if (dbgExpQ.size() != 0) check("dbg data", dbgData, dbgExpQ.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        write    = 1'b0; wrAddr  = '0; wrData  = '0; rdAddr  = '0;
        dbgReq   = 1'b0; dbgAddr = '0;
        writeB   = 1'b0; wrAddrB = '0; wrDataB = '0; rdAddrB = '0;
        dbgReqB  = 1'b0; dbgAddrB = '0;
        repeat (2) @(negedge clk);

        check("reset ready",   ready,   0);
        check("reset rdData",  rdData,  0);
        check("reset dbgAck",  dbgAck,  0);
        check("reset dbgData", dbgData, 0);
        check("reset readyB",  readyB,  0);
        check("reset rdDataB", rdDataB, 0);

        // Debug request held across the whole sweep; write to x3 during CLEAR
        dbgReq  = 1'b1;
        dbgAddr = 5'd15;
        dbgExpQ.push_back(32'h0000BEEF);
        rdAddr  = {5'd3, 5'd3};
        reset_n = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            if (n == 5) doWrite(5'd3, 32'hDEADBEEF);
            step();
            check("sweep ready",  ready,  n == 32);
            check("sweep readyB", readyB, n >= 16);
            check("sweep dbgAck", dbgAck, 0);
            check("sweep rdData", rdData, 0);
        end

        // Edge 33: first write (x15) and first debug acceptance together
        doWrite(5'd15, 32'h0000BEEF);
        step();
        waitAck("dbg after sweep", 4);
        dbgReq = 1'b0;
        step();
        check("dbg single ack", dbgAck, 0);

        // All addresses on both ports: only x15 is non-zero; x3 write was dropped
        for (int a = 0; a < 32; a++) begin
            issueRead(AW'(a), AW'(31 - a),
                      (a == 15) ? 32'h0000BEEF : 32'h0,
                      ((31 - a) == 15) ? 32'h0000BEEF : 32'h0);
            step();
        end

        // Write then read next cycle on both ports
        doWrite(5'd7, 32'h12345678);
        step();
        issueRead(5'd7, 5'd7, 32'h12345678, 32'h12345678);
        step();
        // Zero register: same-cycle and next-cycle reads of x0
        doWrite(5'd0, 32'hFFFFFFFF);
        issueRead(5'd0, 5'd0, 32'h0, 32'h0);
        step();
        issueRead(5'd0, 5'd3, 32'h0, 32'h0);
        step();
        // Same-cycle forwarding on port 0, neighbour unaffected
        doWrite(5'd9, 32'hA5A5A5A5);
        issueRead(5'd9, 5'd8, 32'hA5A5A5A5, 32'h0);
        step();
        issueRead(5'd8, 5'd9, 32'h0, 32'hA5A5A5A5);
        step();
        // Same-cycle forwarding on port 1
        doWrite(5'd20, 32'hCAFE0001);
        issueRead(5'd21, 5'd20, 32'h0, 32'hCAFE0001);
        step();
        step();

        // Debug read of x0 returns 0
        dbgReq  = 1'b1;
        dbgAddr = 5'd0;
        dbgExpQ.push_back(32'h0);
        step();
        waitAck("dbg zero", 4);
        dbgReq = 1'b0;
        step();

        // Back-to-back: request held through the ack cycle
        dbgReq  = 1'b1;
        dbgAddr = 5'd9;
        dbgExpQ.push_back(32'hA5A5A5A5);
        dbgExpQ.push_back(32'hA5A5A5A5);
        step();
        waitAck("dbg b2b first", 4);
        step();
        waitAck("dbg b2b second", 6);
        dbgReq = 1'b0;
        step();
        step();

        // Debug forwarding: write to the captured address on the answer edge
        dbgReq  = 1'b1;
        dbgAddr = 5'd20;
        dbgExpQ.push_back(32'hCAFEF00D);
        step();
        doWrite(5'd20, 32'hCAFEF00D);
        step();
        waitAck("dbg forward", 2);
        dbgReq = 1'b0;
        step();
        issueRead(5'd20, 5'd20, 32'hCAFEF00D, 32'hCAFEF00D);
        step();
        step();

        // Reset in the middle of a debug transaction: no ack may follow
        dbgReq  = 1'b1;
        dbgAddr = 5'd7;
        step();
        #1;
        reset_n = 1'b0;
        dbgReq  = 1'b0;
        #1;
        check("mid-dbg reset dbgAck",  dbgAck,  0);
        check("mid-dbg reset dbgData", dbgData, 0);
        check("mid-dbg reset ready",   ready,   0);
        check("mid-dbg reset rdData",  rdData,  0);
        step();

        // Sweep interrupted at edge 10 with a pending debug request
        dbgReq  = 1'b1;
        dbgAddr = 5'd3;
        reset_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            check("partial sweep ready", ready, 0);
        end
        reset_n = 1'b0;
        dbgReq  = 1'b0;
        step();
        reset_n = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            step();
            check("resweep ready",  ready,  n == 32);
            check("resweep readyB", readyB, n >= 16);
        end
        step();
        check("no ack after dropped request", dbgAck, 0);

        // Contents cleared by the new sweep
        issueRead(5'd7, 5'd20, 32'h0, 32'h0);
        step();
        step();

        // Instance B: three simultaneous reads, plus forwarding on port 0
        doWriteB(4'd1, 16'h1111);
        step();
        doWriteB(4'd2, 16'h2222);
        step();
        issueReadB(4'd1, 4'd2, 4'd1, {16'h1111, 16'h2222, 16'h1111});
        step();
        doWriteB(4'd5, 16'h5555);
        issueReadB(4'd5, 4'd0, 4'd2, {16'h2222, 16'h0000, 16'h5555});
        step();
        repeat (3) step();

        check("rd queue drained",  rdExpQ.size(),  0);
        check("rdB queue drained", rdExpQB.size(), 0);
        check("dbg queue drained", dbgExpQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised register file for the RISC-V core that generalises the fixed two-read-port, 32×32 block-RAM register file to any width, depth and read-port count. Storage is one block-RAM-inferable bank per read port plus one bank for a debug port, all written identically. After reset a hardware sweep zeroes every entry before the core may use the file. A req/ack debug read port replaces the hard-wired LED probe of register 15.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; depth = 2^ADDR_WIDTH
- NUM_READ_PORTS, 2, number of independent read ports (≥1)
- ZERO_REG, 1, when 1, address 0 reads as 0 and ignores writes

Ports:
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- write  in  1  write enable
- wrAddr  in  ADDR_WIDTH  write address
- wrData  in  DATA_WIDTH  write data
- rdAddr  in  NUM_READ_PORTS*ADDR_WIDTH  read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- rdData  out  NUM_READ_PORTS*DATA_WIDTH  read data; port k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- ready  out  1  high once the clear sweep has finished
- dbgReq  in  1  debug read request (level)
- dbgAddr  in  ADDR_WIDTH  debug read address, stable while dbgReq high
- dbgAck  out  1  one-cycle pulse: dbgData valid
- dbgData  out  DATA_WIDTH  debug read result, held until next ack

## Operation
- Reset values: ready=0, rdData=0, dbgAck=0, dbgData=0, sweep counter=0, state=CLEAR, debug FSM=IDLE.
- Top FSM: CLEAR → READY. No other transitions except reset.
  - CLEAR: each cycle writes 0 to address = counter in every bank, counter++. On the write of address 2^ADDR_WIDTH−1, go to READY. In CLEAR, external writes are dropped, rdData reads 0, debug requests stay pending.
  - READY: normal operation.
- Write: committed on the rising edge when write=1, state=READY, and not (ZERO_REG=1 and wrAddr=0). The write goes to all banks.
- Read (READY): rdData[k] ← bank_k[rdAddr[k]], registered.
  - If ZERO_REG=1 and rdAddr[k]=0, the result is 0.
  - If a committing write to the same address occurs in the same cycle, the result is wrData (write-first forwarding).
- Debug FSM: IDLE → BUSY when dbgReq=1 and state=READY, capturing dbgAddr. BUSY → IDLE next edge, asserting dbgAck for that cycle with dbgData = the debug bank read, using the same zero and forwarding rules as the read ports.
  - dbgReq must stay high until the ack.
  - The next request is accepted no earlier than the cycle after the ack.
  - If dbgReq is still high in the ack cycle, it is treated as a new request only from the following cycle.
- Reset asserted at any time, including mid-sweep or mid-debug: all state returns to reset values and the sweep restarts from address 0. Memory contents are not relied upon.

## Timing
- Sweep: the first rising edge after reset_n deasserts writes address 0. Edge n writes address n−1. ready goes high on edge 2^ADDR_WIDTH (edge 32 at default) and is usable from that cycle.
- The first external write and the first debug acceptance can occur on edge 2^ADDR_WIDTH+1.
- Read latency: 1 cycle, address at edge t, data valid after edge t+1. Full throughput, new address every cycle.
- Write → read of the same address: same cycle = forwarded. Later cycles = from bank.
- Debug: request sampled at edge t (IDLE, READY). dbgAck high for one cycle after edge t+1. Minimum 2 cycles per transaction.
- Width rule: all data paths are exactly DATA_WIDTH. No sign extension; addresses are never truncated.

## Test plan
- Reset release, defaults: ready=0 for 32 edges, high after edge 32. Read all 32 addresses on both ports → 0. A write of 0xDEADBEEF to addr 3 during CLEAR is dropped; reading addr 3 → 0.
- Write 0x12345678 to addr 7, then read addr 7 on port 0 and port 1 next cycle → both return 0x12345678 one cycle after the address. Writing 0xFFFFFFFF to addr 0 → reads 0.
- Simultaneous write 0xA5A5A5A5 to addr 9 with rdAddr[0]=9 in the same cycle → rdData[0]=0xA5A5A5A5 after one edge. rdAddr[1]=8 is unaffected.
- Debug: dbgReq with dbgAddr=15 held from mid-CLEAR, after x15 was written with 0x0000BEEF → no ack until READY, then a single one-cycle dbgAck with dbgData=0x0000BEEF. Back-to-back requests get acks no closer than 2 cycles apart.
- Reset pulse at sweep edge 10 → ready stays 0. The sweep restarts at 0 and ready rises 32 edges after the new deassertion. A pending debug request is dropped with no ack.
- NUM_READ_PORTS=3, DATA_WIDTH=16, ADDR_WIDTH=4 → ready after 16 edges. Three simultaneous reads of addrs 1, 2, 1 after writes 0x1111 and 0x2222 return 0x1111, 0x2222, 0x1111.
